// File: rtl/btn_pkg.sv
// Shared constants for the push-button / slide-switch input conditioner:
// input bit positions, debounce defaults and 50 MHz tick-rate constants.
package btn_pkg;

    localparam int BTN0 = 0;
    localparam int BTN1 = 1;
    localparam int BTN2 = 2;
    localparam int BTN3 = 3;
    localparam int SW0  = 4;
    localparam int SW1  = 5;
    localparam int SW2  = 6;
    localparam int SW3  = 7;
    localparam int SW4  = 8;
    localparam int SW5  = 9;
    localparam int SW6  = 10;
    localparam int SW7  = 11;

    localparam int N_IN_DEF         = 12;
    localparam int STABLE_TICKS_DEF = 4;
    localparam int CNT_W_DEF        = 4;

    // A 1 kHz tick from the 50 MHz system clock gives a 4 ms debounce window.
    localparam int CLK_HZ     = 50_000_000;
    localparam int TICK_HZ    = 1_000;
    localparam int TICK_DIV   = CLK_HZ / TICK_HZ;
    localparam int TICK_DIV_W = $clog2(TICK_DIV);

    // Worst-case clean-edge to stable-change latency in system clocks.
    function automatic int debounce_latency_clks(input int stable_ticks);
        return 2 + stable_ticks * TICK_DIV;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-input conditioner: 2-FF synchroniser, tick-driven debounce counter,
// registered rise/fall pulses; adds a key-repeat counter under BTN_DEBOUNCE_AUTOREPEAT_EN.
module debounce_bit
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int CNT_W        = CNT_W_DEF
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter bit REP_EN       = 1'b0,
    parameter int REP_DELAY    = 500,
    parameter int REP_RATE     = 100
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             rep_fire;

    // NOTE: reset is synchronous, so it is just the highest-priority branch of the
    // clocked block; all state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= rep_fire;
            fall <= 1'b0;
            // Any agreement between input and accepted level discards the count.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt < CNT_W'(STABLE_TICKS - 1)) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    stable <= s2;
                    cnt    <= '0;
                    rise   <= s2;
                    fall   <= ~s2;
                end
            end
        end
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_limit;
    logic             rep_armed;

    // First repeat waits REP_DELAY ticks, later ones REP_RATE ticks.
    always_comb begin
        rep_limit = rep_armed ? REP_W'(REP_RATE - 1) : REP_W'(REP_DELAY - 1);
        rep_fire  = REP_EN && stable && tick && (rep_cnt == rep_limit);
    end

    always_ff @(posedge clk) begin
        if (reset || !stable || !REP_EN) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (tick) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Board input conditioner: N_IN independent debounce_bit channels plus sticky
// press flags. Optional key auto-repeat is enabled by BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_IN         = N_IN_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int CNT_W        = CNT_W_DEF
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter logic [N_IN-1:0] REP_MASK = N_IN'(4'b1111),
    parameter int              REP_DELAY = 500,
    parameter int              REP_RATE  = 100
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic [N_IN-1:0] raw,
    input  logic [N_IN-1:0] clr,
    output logic [N_IN-1:0] stable,
    output logic [N_IN-1:0] rise,
    output logic [N_IN-1:0] fall,
    output logic [N_IN-1:0] held
);

    for (genvar i = 0; i < N_IN; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W)
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            ,
            .REP_EN       (REP_MASK[i]),
            .REP_DELAY    (REP_DELAY),
            .REP_RATE     (REP_RATE)
`endif
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .raw    (raw[i]),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // A press arriving in the same cycle as a software clear must not be lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            held <= '0;
        end else begin
            held <= (held & ~clr) | rise;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce: reset, clean press, bounce
// rejection, set/clear collision, mid-debounce reset, multi-bit and auto-repeat.
module tb_btn_debounce;

    localparam int N = 12;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         tick  = 1'b0;
    logic [N-1:0] raw   = '0;
    logic [N-1:0] clr   = '0;
    logic [N-1:0] stable;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] held;

    int n_tests = 0;
    int n_fail  = 0;
    int tdiv    = 0;

    btn_debounce #(
        .N_IN         (N),
        .STABLE_TICKS (4),
        .CNT_W        (4)
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        ,
        .REP_MASK     (12'h00F),
        .REP_DELAY    (5),
        .REP_RATE     (2)
`endif
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .raw    (raw),
        .clr    (clr),
        .stable (stable),
        .rise   (rise),
        .fall   (fall),
        .held   (held)
    );

    always #5 clk = ~clk;

    // One-clk tick every 10 clocks, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv == 9) ? 0 : tdiv + 1;
            tick = (tdiv == 9);
        end
    end

    // Leaves the bench at a falling edge just before a ticked rising edge.
    task automatic align_tick();
        int k;
        k = 0;
        @(negedge clk);
        while (tick !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (tick !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL align_tick: tick=%b required 1 within 20 clk", tick);
        end
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset();
        int first, cnt;
        logic [N-1:0] rv, fall_acc;
        reset = 1'b1;
        raw   = '1;
        clr   = '0;
        settle(3);
        n_tests++; if (stable !== 12'h000) begin n_fail++; $display("FAIL reset_stable: got %h required 000", stable); end
        n_tests++; if (rise   !== 12'h000) begin n_fail++; $display("FAIL reset_rise: got %h required 000", rise); end
        n_tests++; if (fall   !== 12'h000) begin n_fail++; $display("FAIL reset_fall: got %h required 000", fall); end
        n_tests++; if (held   !== 12'h000) begin n_fail++; $display("FAIL reset_held: got %h required 000", held); end
        align_tick();
        reset = 1'b0;
        first = -1; cnt = 0; rv = '0; fall_acc = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            fall_acc |= fall;
            if (rise != '0) begin
                cnt++;
                if (first < 0) begin first = n; rv = rise; end
            end
        end
        n_tests++; if (first != 41)     begin n_fail++; $display("FAIL reset_latency: got %0d clk required 41", first); end
        n_tests++; if (rv !== 12'hFFF)  begin n_fail++; $display("FAIL reset_rise_val: got %h required fff", rv); end
        n_tests++; if (cnt != 1)        begin n_fail++; $display("FAIL reset_rise_once: got %0d pulses required 1", cnt); end
        n_tests++; if (stable !== 12'hFFF) begin n_fail++; $display("FAIL reset_stable_hi: got %h required fff", stable); end
        n_tests++; if (held !== 12'hFFF)   begin n_fail++; $display("FAIL reset_held_set: got %h required fff", held); end
        n_tests++; if (fall_acc !== 12'h000) begin n_fail++; $display("FAIL reset_no_fall: got %h required 000", fall_acc); end
        clr = '1;
        @(negedge clk);
        clr = '0;
        n_tests++; if (held !== 12'h000) begin n_fail++; $display("FAIL clr_all: got %h required 000", held); end
        raw = '0;
        fall_acc = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            fall_acc |= fall;
        end
        n_tests++; if (stable !== 12'h000)  begin n_fail++; $display("FAIL release_stable: got %h required 000", stable); end
        n_tests++; if (fall_acc !== 12'hFFF) begin n_fail++; $display("FAIL release_fall: got %h required fff", fall_acc); end
        n_tests++; if (held[11:4] !== 8'h00) begin n_fail++; $display("FAIL held_ignores_fall: got %h required 00", held[11:4]); end
    endtask

    task automatic test_press();
        int first, cnt;
        logic st_before, st_at, held_at, held_next;
        align_tick();
        raw[0] = 1'b1;
        first = -1; cnt = 0; st_before = 1'bx; st_at = 1'bx; held_at = 1'bx; held_next = 1'bx;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 40) st_before = stable[0];
            if (rise[0]) begin
                cnt++;
                if (first < 0) begin first = n; st_at = stable[0]; held_at = held[0]; end
            end
            if (first > 0 && n == first + 1) held_next = held[0];
        end
        n_tests++; if (first != 41)       begin n_fail++; $display("FAIL press_latency: got %0d clk required 41", first); end
        n_tests++; if (st_before !== 1'b0) begin n_fail++; $display("FAIL press_stable_early: got %b required 0", st_before); end
        n_tests++; if (st_at !== 1'b1)     begin n_fail++; $display("FAIL press_stable: got %b required 1", st_at); end
        n_tests++; if (cnt != 1)           begin n_fail++; $display("FAIL press_rise_width: got %0d clk required 1", cnt); end
        n_tests++; if (held_at !== 1'b0)   begin n_fail++; $display("FAIL press_held_early: got %b required 0", held_at); end
        n_tests++; if (held_next !== 1'b1) begin n_fail++; $display("FAIL press_held: got %b required 1", held_next); end
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        n_tests++; if (held[0] !== 1'b0) begin n_fail++; $display("FAIL press_clr: got %b required 0", held[0]); end
        raw[0] = 1'b0;
        settle(60);
    endtask

    task automatic test_bounce();
        int bounce_pulses, cnt, lat, since;
        bounce_pulses = 0; cnt = 0; lat = -1; since = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rise[1] || fall[1]) bounce_pulses++;
            since++;
            if (k > 0 && k % 15 == 0) begin
                raw[1] = ~raw[1];
                since = 0;
            end
        end
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            since++;
            if (rise[1]) begin
                cnt++;
                if (lat < 0) lat = since;
            end
            if (fall[1]) bounce_pulses++;
        end
        n_tests++; if (bounce_pulses != 0) begin n_fail++; $display("FAIL bounce_reject: got %0d pulses required 0", bounce_pulses); end
        n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL bounce_settle_rise: got %0d required 1", cnt); end
        n_tests++; if (lat < 33 || lat > 42) begin n_fail++; $display("FAIL bounce_latency: got %0d clk required 33..42", lat); end
        raw[1] = 1'b0;
        settle(60);
    endtask

    task automatic test_collision();
        int first;
        logic h1, h2;
        clr[2] = 1'b1;
        align_tick();
        raw[2] = 1'b1;
        first = -1; h1 = 1'bx; h2 = 1'bx;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (rise[2] && first < 0) first = n;
            if (first > 0 && n == first + 1) h1 = held[2];
            if (first > 0 && n == first + 2) h2 = held[2];
        end
        n_tests++; if (first != 41) begin n_fail++; $display("FAIL collide_latency: got %0d clk required 41", first); end
        n_tests++; if (h1 !== 1'b1) begin n_fail++; $display("FAIL collide_set_wins: got %b required 1", h1); end
        n_tests++; if (h2 !== 1'b0) begin n_fail++; $display("FAIL collide_then_clr: got %b required 0", h2); end
        clr[2] = 1'b0;
        raw[2] = 1'b0;
        settle(60);
    endtask

    task automatic test_mid_reset();
        int first, early;
        align_tick();
        raw[3] = 1'b1;
        early = 0;
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk);
            if (rise[3]) early++;
        end
        reset = 1'b1;
        settle(3);
        n_tests++; if (stable !== 12'h000) begin n_fail++; $display("FAIL midrst_stable: got %h required 000", stable); end
        align_tick();
        reset = 1'b0;
        first = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (rise[3] && first < 0) first = n;
        end
        n_tests++; if (early != 0)  begin n_fail++; $display("FAIL midrst_early_rise: got %0d required 0", early); end
        n_tests++; if (first != 41) begin n_fail++; $display("FAIL midrst_latency: got %0d clk required 41", first); end
        raw[3] = 1'b0;
        settle(60);
    endtask

    task automatic test_multi();
        int first, cnt;
        logic [N-1:0] rv;
        align_tick();
        raw = 12'hA50;
        first = -1; cnt = 0; rv = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (rise != '0) begin
                cnt++;
                if (first < 0) begin first = n; rv = rise; end
            end
        end
        n_tests++; if (first != 41)    begin n_fail++; $display("FAIL multi_latency: got %0d clk required 41", first); end
        n_tests++; if (rv !== 12'hA50) begin n_fail++; $display("FAIL multi_rise: got %h required a50", rv); end
        n_tests++; if (cnt != 1)       begin n_fail++; $display("FAIL multi_rise_once: got %0d required 1", cnt); end
        n_tests++; if (held !== 12'hA58) begin n_fail++; $display("FAIL multi_held: got %h required a58", held); end
        clr = 12'hFF0;
        @(negedge clk);
        clr = '0;
        n_tests++; if (held !== 12'h008) begin n_fail++; $display("FAIL multi_clr: got %h required 008", held); end
        raw = '0;
        settle(60);
    endtask

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int first, cnt0, cnt4, after, k;
        align_tick();
        raw[0] = 1'b1;
        raw[4] = 1'b1;
        first = -1;
        for (int n = 1; n <= 60 && first < 0; n++) begin
            @(negedge clk);
            if (rise[0]) first = n;
        end
        cnt0 = (first > 0) ? 1 : 0;
        cnt4 = (first > 0 && rise[4]) ? 1 : 0;
        for (int n = 1; n < 200; n++) begin
            @(negedge clk);
            if (rise[0]) cnt0++;
            if (rise[4]) cnt4++;
        end
        n_tests++; if (first != 41) begin n_fail++; $display("FAIL rep_first: got %0d clk required 41", first); end
        n_tests++; if (cnt0 != 9)   begin n_fail++; $display("FAIL rep_count: got %0d required 9", cnt0); end
        n_tests++; if (cnt4 != 1)   begin n_fail++; $display("FAIL rep_switch: got %0d required 1", cnt4); end
        raw[0] = 1'b0;
        raw[4] = 1'b0;
        k = 0;
        while (!fall[0] && k < 60) begin
            @(negedge clk);
            k++;
        end
        after = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (rise[0]) after++;
        end
        n_tests++; if (k >= 60)   begin n_fail++; $display("FAIL rep_release: fall not seen within %0d clk", k); end
        n_tests++; if (after != 0) begin n_fail++; $display("FAIL rep_after_release: got %0d required 0", after); end
    endtask
`endif

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_collision();
        test_mid_reset();
        test_multi();
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
